// File: rtl/vx_warp_ibuf_pkg.sv
// Shared types and sizing for the per-warp instruction buffer.
package vx_warp_ibuf_pkg;

    localparam int unsigned NUM_WARPS   = 4;
    localparam int unsigned NUM_THREADS = 4;
    localparam int unsigned PC_BITS     = 31;
    localparam int unsigned UUID_WIDTH  = 44;
    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned IBUF_SIZE   = 4;

    localparam int unsigned NW_WIDTH = $clog2(NUM_WARPS);

    // One buffered fetch response; the warp id is implied by which FIFO holds it.
    typedef struct packed {
        logic [UUID_WIDTH-1:0]  uuid;
        logic [PC_BITS-1:0]     pc;
        logic [NUM_THREADS-1:0] tmask;
        logic [INSTR_WIDTH-1:0] instr;
    } ibuf_entry_t;

    localparam int unsigned ENTRY_WIDTH = $bits(ibuf_entry_t);

endpackage

// File: rtl/vx_ibuf_fifo.sv
// Single-warp circular FIFO; storage has no reset so it maps onto LUTRAM.
module vx_ibuf_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;

    // Entry storage: write-only port, caller guarantees push only when not full.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + PtrW'(1);
            if (pop_i)  rptr_q <= rptr_q + PtrW'(1);
            if (push_i && !pop_i) begin
                count_q <= count_q + CntW'(1);
            end else if (!push_i && pop_i) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));

endmodule

// File: rtl/vx_warp_ibuf.sv
// Per-warp instruction buffer: one FIFO per warp, round-robin drain into a
// registered valid/ready output towards decode.
module vx_warp_ibuf
    import vx_warp_ibuf_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [NW_WIDTH-1:0]    in_wid,
    input  logic [PC_BITS-1:0]     in_PC,
    input  logic [NUM_THREADS-1:0] in_tmask,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    input  logic [UUID_WIDTH-1:0]  in_uuid,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [NW_WIDTH-1:0]    out_wid,
    output logic [PC_BITS-1:0]     out_PC,
    output logic [NUM_THREADS-1:0] out_tmask,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [UUID_WIDTH-1:0]  out_uuid,
    input  logic                   out_ready,
    output logic [NUM_WARPS-1:0]   ibuf_pop
);

    ibuf_entry_t            in_entry;
    logic [ENTRY_WIDTH-1:0] head_raw [NUM_WARPS];
    logic [NUM_WARPS-1:0]   empty, full, push, pop;
    logic                   in_fire;
    logic                   any_cand, deq;
    logic [NW_WIDTH-1:0]    grant;

    logic                   out_valid_q;
    logic [NW_WIDTH-1:0]    out_wid_q, rr_q;
    ibuf_entry_t            out_q;

    assign in_entry = '{uuid: in_uuid, pc: in_PC, tmask: in_tmask, instr: in_instr};

    // Ready looks only at occupancy, never at a same-cycle pop.
    assign in_ready = !full[in_wid];
    assign in_fire  = in_valid && in_ready;

    // Route the accepted response to its warp's FIFO.
    always_comb begin
        push = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            push[w] = in_fire && (in_wid == NW_WIDTH'(w));
        end
    end

    for (genvar g = 0; g < NUM_WARPS; g++) begin : g_fifo
        vx_ibuf_fifo #(
            .Depth(IBUF_SIZE),
            .Width(ENTRY_WIDTH)
        ) u_fifo (
            .clk    (clk),
            .reset  (reset),
            .push_i (push[g]),
            .pop_i  (pop[g]),
            .wdata_i(in_entry),
            .rdata_o(head_raw[g]),
            .empty_o(empty[g]),
            .full_o (full[g])
        );
    end

    // Round-robin scan from rr_q+1; descending loop lets the nearest candidate win.
    always_comb begin
        logic [NW_WIDTH-1:0] idx;
        grant    = '0;
        any_cand = 1'b0;
        for (int i = NUM_WARPS; i >= 1; i--) begin
            idx = rr_q + NW_WIDTH'(i);
            if (!empty[idx]) begin
                grant    = idx;
                any_cand = 1'b1;
            end
        end
    end

    // Dequeue whenever the output register is free or being drained this cycle.
    assign deq      = any_cand && (!out_valid_q || out_ready) && !reset;
    assign pop      = deq ? (NUM_WARPS'(1) << grant) : '0;
    assign ibuf_pop = pop;

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_wid_q   <= '0;
            out_q       <= '0;
            rr_q        <= NW_WIDTH'(NUM_WARPS - 1);
        end else if (deq) begin
            out_valid_q <= 1'b1;
            out_wid_q   <= grant;
            out_q       <= ibuf_entry_t'(head_raw[grant]);
            rr_q        <= grant;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_wid   = out_wid_q;
    assign out_PC    = out_q.pc;
    assign out_tmask = out_q.tmask;
    assign out_instr = out_q.instr;
    assign out_uuid  = out_q.uuid;

endmodule
